dma_sched: RTL and testbench



---
 rtl/dma_sched.sv | 248 ++++++++++++++++++++++++
 tb/tb_dma_sched.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_sched.sv
// Round-robin DMA job scheduler: arbitrates requesters, programs the DMA
// register block over a single-beat AXI write master and waits for its irq.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_SIZE_WORD
`define AXI_SIZE_WORD 3'b010
`endif
`ifndef AXI_BURST_INC
`define AXI_BURST_INC 2'b01
`endif

module dma_sched #(
    parameter int          NREQ     = 2,
    parameter logic [31:0] DMA_BASE = 32'h0003_0000,
    parameter int          MAX_NUM  = 64,
    parameter int          TIMEOUT  = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*32-1:0]         req_src,
    input  logic [NREQ*32-1:0]         req_dst,
    input  logic [NREQ*32-1:0]         req_num,
    input  logic [NREQ-1:0]            req_type,
    output logic [NREQ-1:0]            job_done,
    output logic [NREQ-1:0]            job_err,
    output logic                       busy,
    output logic [`AXI_ID_BITS-1:0]    AWID,
    output logic [`AXI_ADDR_BITS-1:0]  AWADDR,
    output logic [`AXI_LEN_BITS-1:0]   AWLEN,
    output logic [`AXI_SIZE_BITS-1:0]  AWSIZE,
    output logic [1:0]                 AWBURST,
    output logic                       AWVALID,
    input  logic                       AWREADY,
    output logic [`AXI_DATA_BITS-1:0]  WDATA,
    output logic [`AXI_STRB_BITS-1:0]  WSTRB,
    output logic                       WLAST,
    output logic                       WVALID,
    input  logic                       WREADY,
    input  logic [`AXI_ID_BITS-1:0]    BID,
    input  logic [1:0]                 BRESP,
    input  logic                       BVALID,
    output logic                       BREADY,
    input  logic                       dma_irq
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [3:0] {
        IDLE, WR_SRC, WR_DST, WR_NUM, WR_TYPE, WR_EN, WAIT_IRQ, WR_CLR, FIN
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] last_q, last_d, gnt_q, gnt_d, pick;
    logic [31:0]   src_q, src_d, dst_q, dst_d, num_q, num_d;
    logic [31:0]   wd_q, wd_d, addr_q, addr_d, data_q, data_d;
    logic          typ_q, typ_d, err_q, err_d, irq_q, irq_d;
    logic          aw_q, aw_d, w_q, w_d, busy_q, busy_d, found;
    logic [NREQ-1:0] rdy_q, rdy_d, done_q, done_d, jerr_q, jerr_d;
    logic          wr_st, bfire, bbad;
    int            idx;

    function automatic logic is_wr(input state_t s);
        return s inside {WR_SRC, WR_DST, WR_NUM, WR_TYPE, WR_EN, WR_CLR};
    endfunction

    function automatic logic [31:0] reg_off(input state_t s);
        unique case (s)
            WR_SRC:  reg_off = 32'h00;
            WR_DST:  reg_off = 32'h04;
            WR_NUM:  reg_off = 32'h08;
            WR_TYPE: reg_off = 32'h14;
            WR_EN:   reg_off = 32'h0c;
            default: reg_off = 32'h10;
        endcase
    endfunction

    function automatic state_t nxt(input state_t s);
        unique case (s)
            WR_SRC:  nxt = WR_DST;
            WR_DST:  nxt = WR_NUM;
            WR_NUM:  nxt = WR_TYPE;
            WR_TYPE: nxt = WR_EN;
            WR_EN:   nxt = WAIT_IRQ;
            default: nxt = FIN;
        endcase
    endfunction

    assign wr_st  = is_wr(state_q);
    assign BREADY = wr_st && !aw_q && !w_q;
    assign bfire  = BVALID && BREADY;
    assign bbad   = BRESP != 2'b00;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        src_d   = src_q;
        dst_d   = dst_q;
        num_d   = num_q;
        typ_d   = typ_q;
        err_d   = err_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wd_d    = '0;
        rdy_d   = '0;
        done_d  = '0;
        jerr_d  = '0;
        aw_d    = aw_q && !AWREADY;
        w_d     = w_q && !WREADY;
        irq_d   = irq_q | (dma_irq &&
                  (state_q inside {WR_EN, WAIT_IRQ, WR_CLR, FIN}));
        found   = 1'b0;
        pick    = '0;
        idx     = 0;
        // Search begins just after the last winner so nobody starves
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_q) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
        unique case (state_q)
            IDLE: if (found) begin
                rdy_d  = NREQ'(1) << pick;
                gnt_d  = pick;
                last_d = pick;
                src_d  = req_src[int'(pick)*32 +: 32];
                dst_d  = req_dst[int'(pick)*32 +: 32];
                num_d  = req_num[int'(pick)*32 +: 32];
                typ_d  = req_type[pick];
                err_d  = (num_d == 32'd0) || (num_d > 32'(MAX_NUM));
                state_d = err_d ? FIN : WR_SRC;
            end
            WR_SRC, WR_DST, WR_NUM, WR_TYPE, WR_EN, WR_CLR:
                if (bfire) begin
                    err_d   = err_q | bbad;
                    state_d = bbad ? FIN : nxt(state_q);
                end
            WAIT_IRQ:
                if (irq_q || dma_irq) begin
                    state_d = WR_CLR;
                end else if (wd_q == 32'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = WR_CLR;
                end else begin
                    wd_d = wd_q + 32'd1;
                end
            FIN: begin
                done_d  = NREQ'(1) << gnt_q;
                jerr_d  = err_q ? done_d : '0;
                irq_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q && is_wr(state_d)) begin
            aw_d   = 1'b1;
            w_d    = 1'b1;
            addr_d = DMA_BASE + reg_off(state_d);
            unique case (state_d)
                WR_SRC:  data_d = src_d;
                WR_DST:  data_d = dst_d;
                WR_NUM:  data_d = num_d;
                WR_TYPE: data_d = typ_d ? 32'd2 : 32'd1;
                default: data_d = 32'd1;
            endcase
        end
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= GW'(NREQ - 1);
            gnt_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            num_q   <= '0;
            typ_q   <= 1'b0;
            err_q   <= 1'b0;
            irq_q   <= 1'b0;
            wd_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            aw_q    <= 1'b0;
            w_q     <= 1'b0;
            rdy_q   <= '0;
            done_q  <= '0;
            jerr_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            num_q   <= num_d;
            typ_q   <= typ_d;
            err_q   <= err_d;
            irq_q   <= irq_d;
            wd_q    <= wd_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            aw_q    <= aw_d;
            w_q     <= w_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
            jerr_q  <= jerr_d;
            busy_q  <= busy_d;
        end
    end

    logic unused_bid;
    assign unused_bid = ^BID;

    assign req_ready = rdy_q;
    assign job_done  = done_q;
    assign job_err   = jerr_q;
    assign busy      = busy_q;
    assign AWID      = '0;
    assign AWADDR    = `AXI_ADDR_BITS'(addr_q);
    assign AWLEN     = '0;
    assign AWSIZE    = `AXI_SIZE_WORD;
    assign AWBURST   = `AXI_BURST_INC;
    assign AWVALID   = aw_q;
    assign WDATA     = `AXI_DATA_BITS'(data_q);
    assign WSTRB     = '1;
    assign WLAST     = 1'b1;
    assign WVALID    = w_q;
endmodule

// File: tb/tb_dma_sched.sv
// Scoreboard bench for dma_sched: requester driver, AXI write slave with
// irq generator, and queues of expected register writes and completions.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

module tb_dma_sched;
    localparam int          NREQ = 2;
    localparam logic [31:0] BASE = 32'h0003_0000;
    localparam int          TMO  = 4096;

    logic clk = 0, rst = 1;
    logic [NREQ-1:0] req_valid = '0, req_ready, req_type = '0;
    logic [NREQ*32-1:0] req_src = '0, req_dst = '0, req_num = '0;
    logic [NREQ-1:0] job_done, job_err;
    logic busy;
    logic [`AXI_ID_BITS-1:0] AWID, BID = '0;
    logic [`AXI_ADDR_BITS-1:0] AWADDR;
    logic [`AXI_LEN_BITS-1:0] AWLEN;
    logic [`AXI_SIZE_BITS-1:0] AWSIZE;
    logic [1:0] AWBURST, BRESP = 2'b00;
    logic AWVALID, AWREADY = 1, WVALID, WREADY = 1, WLAST, BREADY;
    logic BVALID = 0, dma_irq = 0;
    logic [`AXI_DATA_BITS-1:0] WDATA;
    logic [`AXI_STRB_BITS-1:0] WSTRB;

    dma_sched #(.NREQ(NREQ), .DMA_BASE(BASE), .MAX_NUM(64), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .req_dst(req_dst), .req_num(req_num),
        .req_type(req_type), .job_done(job_done), .job_err(job_err),
        .busy(busy), .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN),
        .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWVALID(AWVALID),
        .AWREADY(AWREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .WVALID(WVALID), .WREADY(WREADY), .BID(BID), .BRESP(BRESP),
        .BVALID(BVALID), .BREADY(BREADY), .dma_irq(dma_irq)
    );

    always #5 clk = ~clk;

    // irq: 0 = pulse in WR_EN B wait, 1 = never, 2 = late in WAIT_IRQ
    typedef struct {
        logic [31:0] src, dst, num;
        logic typ;
        int eidx;
        int irq;
    } job_t;
    typedef struct { logic [31:0] a, d; } wr_t;
    typedef struct { int who; logic err; logic ill; int t; } dn_t;

    job_t rq[NREQ][$];
    wr_t  exp_w[$];
    dn_t  exp_d[$];
    int   glog[$];
    job_t cur;
    int   n_chk = 0, n_fail = 0, cyc = 0, last = NREQ - 1;
    logic stall = 0;
    logic got_aw = 0, got_w = 0, b_arm = 0, b_drop = 0;
    logic [1:0] b_resp = 0;
    logic [31:0] cap_a, cap_d, offs[6];
    int irq_cnt = 0, t_en = 0, g, eg;
    logic f;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic job_t mk(input logic [31:0] s, d, n, input logic t,
                                input int e, input int q);
        job_t j;
        j.src = s; j.dst = d; j.num = n; j.typ = t; j.eidx = e; j.irq = q;
        return j;
    endfunction

    task automatic accept(input int who, input job_t j);
        logic [31:0] dat[6];
        dn_t e;
        dat = '{j.src, j.dst, j.num, j.typ ? 32'd2 : 32'd1, 32'd1, 32'd1};
        e.who = who; e.t = cyc;
        e.ill = (j.num == 0) || (j.num > 64);
        e.err = e.ill || (j.eidx >= 0) || (j.irq == 1);
        if (!e.ill)
            for (int i = 0; i < 6; i++)
                if (j.eidx < 0 || i <= j.eidx)
                    exp_w.push_back('{BASE + offs[i], dat[i]});
        exp_d.push_back(e);
    endtask

    initial begin
        dn_t e;
        wr_t w;
        offs = '{32'h00, 32'h04, 32'h08, 32'h14, 32'h0c, 32'h10};
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                got_aw = 0; got_w = 0; b_arm = 0; b_drop = 0;
                BVALID = 0; dma_irq = 0; irq_cnt = 0; last = NREQ - 1;
                exp_w.delete(); exp_d.delete();
                for (int i = 0; i < NREQ; i++) rq[i].delete();
                req_valid = '0;
            end else begin
                if (job_done != 0) begin
                    if (exp_d.size() == 0) chk("done_unexp", job_done, 0);
                    else begin
                        e = exp_d.pop_front();
                        chk("done_who", job_done, 32'(1 << e.who));
                        chk("done_err", job_err, e.err ? 32'(1 << e.who) : 0);
                        if (e.ill)
                            chk("ill_lat", 32'((cyc - e.t) inside {[1:2]}), 1);
                    end
                end
                if (req_ready != 0) begin
                    g = 0; f = 0; eg = 0;
                    for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
                    for (int k = 1; k <= NREQ; k++)
                        if (!f && req_valid[(last + k) % NREQ]) begin
                            f = 1; eg = (last + k) % NREQ;
                        end
                    chk("grant", req_ready, 32'(1 << eg));
                    last = g;
                    glog.push_back(g);
                    if (rq[g].size() == 0) chk("grant_nojob", 0, 1);
                    else begin
                        cur = rq[g].pop_front();
                        accept(g, cur);
                    end
                end
                for (int i = 0; i < NREQ; i++) begin
                    req_valid[i] = rq[i].size() > 0;
                    if (req_valid[i]) begin
                        req_src[i*32 +: 32] = rq[i][0].src;
                        req_dst[i*32 +: 32] = rq[i][0].dst;
                        req_num[i*32 +: 32] = rq[i][0].num;
                        req_type[i] = rq[i][0].typ;
                    end
                end
                if (irq_cnt > 0) begin
                    irq_cnt--;
                    dma_irq = irq_cnt == 0;
                end else dma_irq = 0;
                if (b_drop) begin BVALID = 0; b_drop = 0; end
                if (b_arm) begin BVALID = 1; BRESP = b_resp; b_arm = 0; end
                if (BVALID && BREADY) b_drop = 1;
                AWREADY = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                WREADY  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                if (AWVALID && AWREADY && !got_aw) begin
                    got_aw = 1; cap_a = AWADDR;
                end
                if (WVALID && WREADY && !got_w) begin
                    got_w = 1; cap_d = WDATA;
                    chk("wfix", {WLAST, WSTRB}, 5'h1f);
                end
                if (got_aw && got_w) begin
                    got_aw = 0; got_w = 0; b_arm = 1;
                    if (exp_w.size() == 0) chk("wr_unexp", cap_a, 32'hffff_ffff);
                    else begin
                        w = exp_w.pop_front();
                        chk("wr_addr", cap_a, w.a);
                        chk("wr_data", cap_d, w.d);
                    end
                    b_resp = (cur.eidx >= 0 && cap_a == BASE + offs[cur.eidx])
                             ? 2'b10 : 2'b00;
                    if (cap_a == BASE + 32'h0c) begin
                        t_en = cyc;
                        irq_cnt = cur.irq == 0 ? 1 : (cur.irq == 2 ? 8 : 0);
                    end
                    if (cap_a == BASE + 32'h10)
                        chk("clr_gap", 32'(cur.irq == 1 ? (cyc - t_en) >= TMO
                                                         : (cyc - t_en) < 30), 1);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0, pend;
        do begin
            @(negedge clk); #1;
            n++;
            pend = exp_d.size();
            for (int i = 0; i < NREQ; i++) pend += rq[i].size();
        end while ((pend != 0 || busy) && n < 10000);
        chk("idle_reached", 32'(n < 10000), 1);
        chk("wq_empty", exp_w.size(), 0);
    endtask

    task automatic push(input int who, input job_t j);
        @(posedge clk);
        rq[who].push_back(j);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out", {AWVALID, WVALID, BREADY, busy, req_ready,
                        job_done, job_err}, 0);
        @(negedge clk); #2 rst = 0;
        @(posedge clk);
        rq[0].push_back(mk(32'h2000_0000, 32'h1000_0000, 16, 0, -1, 0));
        rq[0].push_back(mk(32'h2000_1000, 32'h1000_2000, 64, 0, -1, 0));
        rq[1].push_back(mk(32'h2000_4000, 32'h1000_8000, 1, 1, -1, 2));
        wait_idle();
        chk("order_n", glog.size(), 3);
        if (glog.size() == 3)
            chk("order", {glog[0][3:0], glog[1][3:0], glog[2][3:0]}, 12'h010);
        push(1, mk(32'h1, 32'h2, 0, 0, -1, 0));
        wait_idle();
        push(0, mk(32'h1, 32'h2, 65, 1, -1, 0));
        wait_idle();
        push(1, mk(32'h3000_0000, 32'h4000_0000, 8, 1, 2, 0));
        wait_idle();
        stall = 1;
        push(0, mk(32'h5555_0000, 32'haaaa_0000, 33, 1, -1, 0));
        wait_idle();
        stall = 0;
        push(1, mk(32'h6000_0000, 32'h7000_0000, 4, 0, -1, 1));
        wait_idle();
        push(0, mk(32'h8000_0000, 32'h9000_0000, 2, 0, -1, 0));
        n = 0;
        do begin @(negedge clk); #1; n++; end
        while (!(AWVALID && AWADDR == BASE + 32'h04) && n < 200);
        chk("reach_dst", 32'(n < 200), 1);
        rst = 1;
        #1;
        chk("rst_mid", {AWVALID, WVALID, BREADY, busy, req_ready,
                        job_done, job_err}, 0);
        repeat (2) @(negedge clk);
        #2 rst = 0;
        push(0, mk(32'h0bad_0000, 32'h0600_d000, 12, 1, -1, 0));
        wait_idle();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout");
        $fatal(1);
    end
endmodule
